// File: rtl/debug_stream_busmaster_pkg.sv
// debug_stream_busmaster_pkg: states and protocol byte constants for the stream bus master
package debug_stream_busmaster_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_ADDR, S_WDATA, S_WRITE, S_READ, S_TX_DATA, S_STATUS
  } state_t;
  localparam logic [7:0] CMD_WRITE       = 8'h57;
  localparam logic [7:0] CMD_READ        = 8'h52;
  localparam logic [7:0] CMD_BLOCK_WRITE = 8'h42;
  localparam logic [7:0] CMD_BLOCK_READ  = 8'h62;
  localparam logic [7:0] STS_OK          = 8'h4B;
  localparam logic [7:0] STS_ERR         = 8'h45;
endpackage

// File: rtl/debug_stream_busmaster_timeout.sv
// bus_timeout_counter: counts pending request cycles and flags the last allowed one
module bus_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic limit
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  // restart on every new request, saturate at the limit while pending
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !limit) cnt <= cnt + 1'b1;
  assign limit = cnt == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/debug_stream_busmaster.sv
// debug_stream_busmaster: UART byte stream to debug bus master with block transfers and timeout
module debug_stream_busmaster
  import debug_stream_busmaster_pkg::*;
#(
  parameter int ADDR_BYTES     = 2,
  parameter int DATA_BYTES     = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              i_com_data,
  input  logic                    i_com_strobe,
  input  logic                    i_com_ready,
  output logic [7:0]              o_com_data,
  output logic                    o_com_strobe,
  output logic                    o_busy,
  output logic [8*ADDR_BYTES-1:0] o_bus_addr,
  output logic [8*DATA_BYTES-1:0] o_bus_wdata,
  output logic                    o_bus_we,
  output logic                    o_bus_re,
  input  logic                    i_bus_ready,
  input  logic [8*DATA_BYTES-1:0] i_bus_rdata,
  input  logic                    i_bus_rvalid
);
  localparam int AW = 8 * ADDR_BYTES;
  localparam int DW = 8 * DATA_BYTES;
  state_t state, state_next;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;
  logic [7:0] cnt;
  logic [1:0] bcnt;
  logic is_wr, err, skip, limit;
  logic cmd_ok, cmd_w, cmd_blk, last_a, last_d, wr_done, rd_done, tx_last;
  assign cmd_w   = i_com_data == CMD_WRITE || i_com_data == CMD_BLOCK_WRITE;
  assign cmd_blk = i_com_data == CMD_BLOCK_WRITE || i_com_data == CMD_BLOCK_READ;
  assign cmd_ok  = cmd_w || cmd_blk || i_com_data == CMD_READ;
  assign last_a  = bcnt == 2'(ADDR_BYTES - 1);
  assign last_d  = bcnt == 2'(DATA_BYTES - 1);
  assign o_bus_we = state == S_WRITE && !skip;
  assign o_bus_re = state == S_READ;
  assign wr_done  = state == S_WRITE && (skip || i_bus_ready || limit);
  assign rd_done  = state == S_READ && (i_bus_rvalid || limit);
  assign o_com_strobe = i_com_ready && (state == S_TX_DATA || state == S_STATUS);
  assign tx_last  = o_com_strobe && state == S_TX_DATA && last_d;
  assign o_com_data = state == S_STATUS ? (err ? STS_ERR : STS_OK) :
                      state == S_TX_DATA ? rdata[DW-1 -: 8] : 8'h00;
  assign o_busy = state != S_IDLE;
  assign o_bus_addr = addr;
  assign o_bus_wdata = wdata;
  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!(o_bus_we || o_bus_re)),
    .en    (o_bus_we || o_bus_re),
    .limit (limit)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_next;
  // next-state decode from received bytes, bus completions and transmit progress
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (i_com_strobe && cmd_ok) state_next = cmd_blk ? S_COUNT : S_ADDR;
      S_COUNT:   if (i_com_strobe) state_next = S_ADDR;
      S_ADDR:    if (i_com_strobe && last_a) state_next = is_wr ? S_WDATA : S_READ;
      S_WDATA:   if (i_com_strobe && last_d) state_next = S_WRITE;
      S_WRITE:   if (wr_done) state_next = cnt == 8'd0 ? S_STATUS : S_WDATA;
      S_READ:    if (rd_done) state_next = S_TX_DATA;
      S_TX_DATA: if (tx_last) state_next = cnt == 8'd0 ? S_STATUS : S_READ;
      S_STATUS:  if (o_com_strobe) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end
  // datapath: field shifting, word counting, address stepping and sticky error
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      addr  <= '0;
      wdata <= '0;
      rdata <= '0;
      cnt   <= '0;
      bcnt  <= '0;
      is_wr <= 1'b0;
      err   <= 1'b0;
      skip  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (i_com_strobe && cmd_ok) begin
          is_wr <= cmd_w;
          cnt   <= '0;
          bcnt  <= '0;
          err   <= 1'b0;
          skip  <= 1'b0;
        end
        S_COUNT: if (i_com_strobe) cnt <= i_com_data;
        S_ADDR: if (i_com_strobe) begin
          addr <= (addr << 8) | AW'(i_com_data);
          bcnt <= last_a ? 2'd0 : bcnt + 2'd1;
        end
        S_WDATA: if (i_com_strobe) begin
          wdata <= (wdata << 8) | DW'(i_com_data);
          bcnt  <= last_d ? 2'd0 : bcnt + 2'd1;
        end
        S_WRITE: if (wr_done) begin
          addr <= addr + 1'b1;
          if (cnt != 8'd0) cnt <= cnt - 8'd1;
          if (!skip && !i_bus_ready) begin
            err  <= 1'b1;
            skip <= 1'b1;
          end
        end
        S_READ: if (rd_done) begin
          rdata <= i_bus_rvalid ? i_bus_rdata : '0;
          err   <= err | !i_bus_rvalid;
          addr  <= addr + 1'b1;
        end
        S_TX_DATA: if (o_com_strobe) begin
          rdata <= rdata << 8;
          bcnt  <= last_d ? 2'd0 : bcnt + 2'd1;
          if (last_d && cnt != 8'd0) cnt <= cnt - 8'd1;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_debug_stream_busmaster.sv
// tb_debug_stream_busmaster: directed checks of commands, latency, back-pressure, timeout and reset
module tb_debug_stream_busmaster;
  logic clk = 0, rst_n = 0;
  logic [7:0] i_com_data = 0;
  logic i_com_strobe = 0, com_ready = 1, toggle = 0;
  logic bus_ready = 1, rvalid_en = 1;
  logic [7:0] o_com_data;
  logic o_com_strobe, o_busy, o_bus_we, o_bus_re, i_bus_ready, i_bus_rvalid;
  logic [15:0] o_bus_addr, o_bus_wdata, i_bus_rdata;
  int checks = 0, errors = 0, cyc = 0, last_cyc = 0, re_n = 0, bp_viol = 0;
  logic [7:0] txq[$];
  int txc[$], wc[$];
  logic [15:0] wa[$], wd[$], ra[$];

  debug_stream_busmaster #(.ADDR_BYTES(2), .DATA_BYTES(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_com_data(i_com_data), .i_com_strobe(i_com_strobe),
    .i_com_ready(com_ready), .o_com_data(o_com_data), .o_com_strobe(o_com_strobe),
    .o_busy(o_busy), .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata), .o_bus_we(o_bus_we),
    .o_bus_re(o_bus_re), .i_bus_ready(i_bus_ready), .i_bus_rdata(i_bus_rdata),
    .i_bus_rvalid(i_bus_rvalid)
  );

  assign i_bus_ready  = bus_ready;
  assign i_bus_rvalid = rvalid_en & o_bus_re;
  assign i_bus_rdata  = 16'h1000 + o_bus_addr;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    com_ready = toggle ? ~com_ready : 1'b1;
  end
  always @(negedge clk) begin
    if (o_com_strobe) begin
      txq.push_back(o_com_data);
      txc.push_back(cyc);
    end
    if (o_com_strobe && !com_ready) bp_viol++;
    if (o_bus_we) begin
      wa.push_back(o_bus_addr);
      wd.push_back(o_bus_wdata);
      wc.push_back(cyc);
    end
    if (o_bus_re) re_n++;
    if (o_bus_re && i_bus_rvalid) ra.push_back(o_bus_addr);
  end

  task send(input logic [7:0] b);
    i_com_data = b;
    i_com_strobe = 1;
    last_cyc = cyc;
    @(posedge clk); #1;
    i_com_strobe = 0;
  endtask

  task wait_idle;
    int n;
    n = 0;
    while (o_busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait: busy=%b required 0 after %0d cycles", o_busy, n);
    end
  endtask

  task test_reset;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_busy, o_bus_we, o_bus_re, o_com_strobe} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: busy/we/re/strobe=%b required 0000", {o_busy, o_bus_we, o_bus_re, o_com_strobe});
    end
    checks++;
    if ({o_bus_addr, o_bus_wdata, o_com_data} !== 40'h0) begin
      errors++;
      $display("FAIL reset_data: addr=%h wdata=%h txdata=%h required 0", o_bus_addr, o_bus_wdata, o_com_data);
    end
    rst_n = 1;
    @(posedge clk); #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b required 0", o_busy);
    end
  endtask

  task test_single_write;
    int tb, wb;
    tb = txq.size();
    wb = wa.size();
    bus_ready = 1;
    send(8'h57); send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
    wait_idle();
    checks++;
    if (wa.size() - wb != 1) begin
      errors++;
      $display("FAIL write_we_cycles: got %0d required 1", wa.size() - wb);
    end else begin
      checks++;
      if (wa[wb] !== 16'h1234 || wd[wb] !== 16'hABCD) begin
        errors++;
        $display("FAIL write_addr_data: addr=%h wdata=%h required 1234 ABCD", wa[wb], wd[wb]);
      end
      checks++;
      if (wc[wb] != last_cyc + 1) begin
        errors++;
        $display("FAIL write_we_latency: cycle %0d required %0d", wc[wb], last_cyc + 1);
      end
    end
    checks++;
    if (txq.size() - tb != 1) begin
      errors++;
      $display("FAIL write_status_count: got %0d bytes required 1", txq.size() - tb);
    end else begin
      checks++;
      if (txq[tb] !== 8'h4B || txc[tb] != last_cyc + 2) begin
        errors++;
        $display("FAIL write_status: byte %h at cycle %0d required 4B at %0d", txq[tb], txc[tb], last_cyc + 2);
      end
    end
  endtask

  task test_block_read(input logic tog);
    int tb, rb;
    logic [7:0] e [7];
    logic [15:0] ea [3];
    e = '{8'h10, 8'hFE, 8'h10, 8'hFF, 8'h11, 8'h00, 8'h4B};
    ea = '{16'h00FE, 16'h00FF, 16'h0100};
    tb = txq.size();
    rb = ra.size();
    rvalid_en = 1;
    toggle = tog;
    send(8'h62); send(8'h02); send(8'h00); send(8'hFE);
    wait_idle();
    toggle = 0;
    checks++;
    if (txq.size() - tb != 7) begin
      errors++;
      $display("FAIL block_read_len tog=%b: got %0d bytes required 7", tog, txq.size() - tb);
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (txq[tb+i] !== e[i]) begin
          errors++;
          $display("FAIL block_read_byte%0d tog=%b: got %h required %h", i, tog, txq[tb+i], e[i]);
        end
      end
      if (!tog) begin
        checks++;
        if (txc[tb] != last_cyc + 2) begin
          errors++;
          $display("FAIL read_latency: cycle %0d required %0d", txc[tb], last_cyc + 2);
        end
      end
    end
    checks++;
    if (ra.size() - rb != 3) begin
      errors++;
      $display("FAIL block_read_count tog=%b: got %0d reads required 3", tog, ra.size() - rb);
    end else
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ra[rb+i] !== ea[i]) begin
          errors++;
          $display("FAIL block_read_addr%0d: got %h required %h", i, ra[rb+i], ea[i]);
        end
      end
    checks++;
    if (bp_viol != 0) begin
      errors++;
      $display("FAIL strobe_without_ready: got %0d required 0", bp_viol);
    end
  endtask

  task test_write_timeout;
    int tb, wb;
    tb = txq.size();
    wb = wa.size();
    bus_ready = 0;
    send(8'h42); send(8'h01); send(8'h00); send(8'h10); send(8'h11); send(8'h22);
    repeat (10) @(posedge clk);
    #1;
    send(8'h33); send(8'h44);
    wait_idle();
    bus_ready = 1;
    checks++;
    if (wa.size() - wb != 8) begin
      errors++;
      $display("FAIL wr_timeout_cycles: we high %0d cycles required 8", wa.size() - wb);
    end else begin
      checks++;
      if (wa[wb+7] !== 16'h0010 || wd[wb+7] !== 16'h1122) begin
        errors++;
        $display("FAIL wr_timeout_addr_data: %h %h required 0010 1122", wa[wb+7], wd[wb+7]);
      end
    end
    checks++;
    if (txq.size() - tb != 1 || txq[txq.size()-1] !== 8'h45) begin
      errors++;
      $display("FAIL wr_timeout_status: %0d bytes last %h required 1 byte 45", txq.size() - tb, txq[txq.size()-1]);
    end
  endtask

  task test_timeout_boundary;
    int tb, wb;
    tb = txq.size();
    wb = wa.size();
    bus_ready = 0;
    send(8'h57); send(8'h00); send(8'h30); send(8'h55); send(8'h66);
    repeat (7) @(posedge clk);
    #1;
    bus_ready = 1;
    @(posedge clk); #1;
    wait_idle();
    checks++;
    if (wa.size() - wb != 8) begin
      errors++;
      $display("FAIL limit_completion_cycles: we high %0d cycles required 8", wa.size() - wb);
    end
    checks++;
    if (txq.size() - tb != 1 || txq[txq.size()-1] !== 8'h4B) begin
      errors++;
      $display("FAIL limit_completion_status: %0d bytes last %h required 1 byte 4B", txq.size() - tb, txq[txq.size()-1]);
    end
  endtask

  task test_read_timeout;
    int tb, rn;
    logic [7:0] e [6];
    e = '{8'h00, 8'h00, 8'h45, 8'h10, 8'h21, 8'h4B};
    tb = txq.size();
    rn = re_n;
    rvalid_en = 0;
    send(8'h52); send(8'h00); send(8'h20);
    wait_idle();
    checks++;
    if (re_n - rn != 8) begin
      errors++;
      $display("FAIL rd_timeout_cycles: re high %0d cycles required 8", re_n - rn);
    end
    rvalid_en = 1;
    send(8'h52); send(8'h00); send(8'h21);
    wait_idle();
    checks++;
    if (txq.size() - tb != 6) begin
      errors++;
      $display("FAIL rd_timeout_len: got %0d bytes required 6", txq.size() - tb);
    end else
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (txq[tb+i] !== e[i]) begin
          errors++;
          $display("FAIL rd_timeout_byte%0d: got %h required %h", i, txq[tb+i], e[i]);
        end
      end
  endtask

  task test_reset_midcmd;
    int tb, wb;
    tb = txq.size();
    wb = wa.size();
    send(8'h58);
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL unknown_cmd_busy: busy=%b required 0", o_busy);
    end
    send(8'h57); send(8'h12); send(8'h34);
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (o_busy !== 1'b0 || txq.size() != tb || wa.size() != wb) begin
      errors++;
      $display("FAIL midcmd_reset: busy=%b tx=%0d we=%0d required 0 0 0", o_busy, txq.size() - tb, wa.size() - wb);
    end
    send(8'h57); send(8'h00); send(8'h05); send(8'hBE); send(8'hEF);
    wait_idle();
    checks++;
    if (wa.size() - wb != 1 || wa[wa.size()-1] !== 16'h0005 || wd[wd.size()-1] !== 16'hBEEF) begin
      errors++;
      $display("FAIL after_reset_write: %0d writes addr=%h wdata=%h required 1 0005 BEEF", wa.size() - wb, wa[wa.size()-1], wd[wd.size()-1]);
    end
    checks++;
    if (txq.size() - tb != 1 || txq[txq.size()-1] !== 8'h4B) begin
      errors++;
      $display("FAIL after_reset_status: %0d bytes last %h required 1 byte 4B", txq.size() - tb, txq[txq.size()-1]);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_block_read(1'b0);
    test_block_read(1'b1);
    test_write_timeout();
    test_timeout_boundary();
    test_read_timeout();
    test_reset_midcmd();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
